hit_detect: RTL and testbench

HIT_DETECT -- requirements
Module: hit_detect

---
 rtl/hit_detect.sv | 208 ++++++++++++++++++++
 tb/tb_hit_detect.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_detect.sv
// Collision detector for the raccoon against three cars.
// A registered overlap stage feeds a hit FSM that emits one pulse per collision,
// then holds off further hits for an invulnerability window, and re-arms only
// after the raccoon has been seen clear of every car.
module hit_detect #(
    parameter int unsigned PLAYER_WIDTH  = 32,
    parameter int unsigned PLAYER_HEIGHT = 32,
    parameter int unsigned CAR_WIDTH     = 32,
    parameter int unsigned CAR_HEIGHT    = 32,
    parameter int unsigned INVULN_CYCLES = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic [1:0] i_Game_State,
    input  logic [9:0] i_Raccoon_X,
    input  logic [9:0] i_Raccoon_Y,
    input  logic [9:0] i_Car1_X,
    input  logic [9:0] i_Car1_Y,
    input  logic [9:0] i_Car2_X,
    input  logic [9:0] i_Car2_Y,
    input  logic [9:0] i_Car3_X,
    input  logic [9:0] i_Car3_Y,
    output logic       o_Hit,
    output logic [1:0] o_Hit_Car,
    output logic       o_Overlap,
    output logic       o_Invuln
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SUM_W   = 11;
    localparam int unsigned CNT_W   = 25;
    localparam int unsigned NUM_CAR = 3;
    localparam int unsigned CAR_W   = 2;

    localparam logic [1:0]       GS_RUNNING  = 2'b01;
    localparam logic [CNT_W-1:0] INVULN_LOAD = CNT_W'(INVULN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARMED      = 3'd1,
        S_HIT        = 3'd2,
        S_INVULN     = 3'd3,
        S_WAIT_CLEAR = 3'd4
    } state_t;

    // Axis-aligned box test; sums widened by one bit so edges near 1023 never wrap.
    function automatic logic f_overlap(
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] cx,
        input logic [COORD_W-1:0] cy
    );
        logic [SUM_W-1:0] p_l;
        logic [SUM_W-1:0] p_r;
        logic [SUM_W-1:0] p_t;
        logic [SUM_W-1:0] p_b;
        logic [SUM_W-1:0] c_l;
        logic [SUM_W-1:0] c_r;
        logic [SUM_W-1:0] c_t;
        logic [SUM_W-1:0] c_b;
        p_l = SUM_W'(px);
        p_t = SUM_W'(py);
        c_l = SUM_W'(cx);
        c_t = SUM_W'(cy);
        p_r = p_l + SUM_W'(PLAYER_WIDTH);
        p_b = p_t + SUM_W'(PLAYER_HEIGHT);
        c_r = c_l + SUM_W'(CAR_WIDTH);
        c_b = c_t + SUM_W'(CAR_HEIGHT);
        return (p_l < c_r) && (p_r > c_l) && (p_t < c_b) && (p_b > c_t);
    endfunction

    logic [NUM_CAR-1:0] w_overlap_vec;
    logic [NUM_CAR-1:0] r_overlap_vec;
    logic               r_overlap;
    logic [CAR_W-1:0]   w_first_car;
    logic [1:0]         r_rst_sync;
    logic               w_run_ok;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_hit;
    logic               w_hit_next;
    logic [CAR_W-1:0]   r_hit_car;
    logic [CAR_W-1:0]   w_hit_car_next;
    logic               r_invuln;
    logic               w_invuln_next;

    // Raw per-car overlap from the current coordinates.
    always_comb begin
        w_overlap_vec[0] = f_overlap(i_Raccoon_X, i_Raccoon_Y, i_Car1_X, i_Car1_Y);
        w_overlap_vec[1] = f_overlap(i_Raccoon_X, i_Raccoon_Y, i_Car2_X, i_Car2_Y);
        w_overlap_vec[2] = f_overlap(i_Raccoon_X, i_Raccoon_Y, i_Car3_X, i_Car3_Y);
    end

    // Stage 1: register the per-car vector and the combined overlap flag.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_overlap_vec <= '0;
            r_overlap     <= 1'b0;
        end else begin
            r_overlap_vec <= w_overlap_vec;
            r_overlap     <= |w_overlap_vec;
        end
    end

    // Lowest-index overlapping car wins when several collide together.
    always_comb begin
        w_first_car = CAR_W'(0);
        if (r_overlap_vec[0]) begin
            w_first_car = CAR_W'(1);
        end else if (r_overlap_vec[1]) begin
            w_first_car = CAR_W'(2);
        end else if (r_overlap_vec[2]) begin
            w_first_car = CAR_W'(3);
        end
    end

    // Reset release is synchronised; the FSM may leave IDLE only once this is full.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run_ok = r_rst_sync[1];

    // Next-state, counter and registered-output decode for the hit FSM.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_hit_car_next = r_hit_car;
        w_hit_next     = 1'b0;
        w_invuln_next  = 1'b0;

        if (i_Game_State != GS_RUNNING) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_run_ok && !r_overlap) begin
                        w_state_next = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (r_overlap) begin
                        w_state_next   = S_HIT;
                        w_hit_car_next = w_first_car;
                        w_cnt_next     = INVULN_LOAD;
                    end
                end
                S_HIT: begin
                    w_state_next = S_INVULN;
                end
                S_INVULN: begin
                    if (r_cnt == '0) begin
                        w_state_next = S_WAIT_CLEAR;
                    end else begin
                        w_cnt_next = r_cnt - CNT_ONE;
                    end
                end
                S_WAIT_CLEAR: begin
                    if (!r_overlap) begin
                        w_state_next = S_ARMED;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end

        if (w_state_next == S_IDLE) begin
            w_hit_car_next = CAR_W'(0);
        end
        w_hit_next    = (w_state_next == S_HIT);
        w_invuln_next = (w_state_next == S_INVULN);
    end

    // State, counter and output registers.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hit     <= 1'b0;
            r_hit_car <= CAR_W'(0);
            r_invuln  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_hit     <= w_hit_next;
            r_hit_car <= w_hit_car_next;
            r_invuln  <= w_invuln_next;
        end
    end

    assign o_Hit     = r_hit;
    assign o_Hit_Car = r_hit_car;
    assign o_Overlap = r_overlap;
    assign o_Invuln  = r_invuln;

endmodule

// File: tb/tb_hit_detect.sv
// Bench for hit_detect: directed scenarios plus random traffic, every cycle
// compared against a timestamp-based model of the collision rules.
module tb_hit_detect;

    localparam int N  = 8;
    localparam int PW = 32;
    localparam int PH = 32;
    localparam int CW = 32;
    localparam int CH = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] gs = 2'b00;
    logic [9:0] rac_x = 10'd100;
    logic [9:0] rac_y = 10'd100;
    logic [9:0] car_x [1:3];
    logic [9:0] car_y [1:3];

    logic       o_hit;
    logic [1:0] o_hit_car;
    logic       o_overlap;
    logic       o_invuln;

    int n_checks = 0;
    int n_pass   = 0;

    // model: registered overlap view, pulse/car/invuln outputs, and event times
    int m_ovl, m_first, m_hit, m_car, m_inv;
    int engaged, hit_at, arm_at, rel, cyc;
    int last_hit, hit_count;

    always #5 clk = ~clk;

    hit_detect #(
        .PLAYER_WIDTH (PW),
        .PLAYER_HEIGHT(PH),
        .CAR_WIDTH    (CW),
        .CAR_HEIGHT   (CH),
        .INVULN_CYCLES(N)
    ) dut (
        .i_Clk       (clk),
        .i_Reset_n   (rst_n),
        .i_Game_State(gs),
        .i_Raccoon_X (rac_x),
        .i_Raccoon_Y (rac_y),
        .i_Car1_X    (car_x[1]),
        .i_Car1_Y    (car_y[1]),
        .i_Car2_X    (car_x[2]),
        .i_Car2_Y    (car_y[2]),
        .i_Car3_X    (car_x[3]),
        .i_Car3_Y    (car_y[3]),
        .o_Hit       (o_hit),
        .o_Hit_Car   (o_hit_car),
        .o_Overlap   (o_overlap),
        .o_Invuln    (o_invuln)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int box_hit(input int px, input int py, input int cx, input int cy);
        return (px < cx + CW && px + PW > cx && py < cy + CH && py + PH > cy) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_ovl = 0; m_first = 0; m_hit = 0; m_car = 0; m_inv = 0;
        engaged = 0; hit_at = -1; arm_at = -1; rel = 0; last_hit = -1;
    endtask

    // One clock of the collision rules, using the inputs present before the edge.
    task automatic model_edge();
        int allowed;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        allowed = (rel >= 2) ? 1 : 0;
        if (rel < 2) rel++;
        m_hit = 0;
        if (gs != 2'b01) begin
            engaged = 0; arm_at = -1; hit_at = -1; m_car = 0; last_hit = -1;
        end else if (engaged == 0) begin
            if (allowed == 1 && m_ovl == 0) begin
                engaged = 1; arm_at = cyc;
            end
        end else if (arm_at >= 0 && m_ovl == 1) begin
            m_hit = 1; hit_at = cyc; arm_at = -1; m_car = m_first;
        end else if (arm_at < 0 && hit_at >= 0 && cyc - 1 > hit_at + N && m_ovl == 0) begin
            arm_at = cyc;
        end
        m_inv = (engaged == 1 && arm_at < 0 && hit_at >= 0 && cyc > hit_at && cyc <= hit_at + N) ? 1 : 0;
        m_first = 0;
        for (int c = 3; c >= 1; c--)
            if (box_hit(int'(rac_x), int'(rac_y), int'(car_x[c]), int'(car_y[c])) == 1) m_first = c;
        m_ovl = (m_first != 0) ? 1 : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("overlap", int'(o_overlap), m_ovl);
        chk("hit", int'(o_hit), m_hit);
        chk("hit_car", int'(o_hit_car), m_car);
        chk("invuln", int'(o_invuln), m_inv);
        if (o_hit) begin
            hit_count++;
            if (last_hit >= 0) chk("hit_spacing", (cyc - last_hit >= N + 2) ? 1 : 0, 1);
            last_hit = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cars_far();
        car_x[1] = 10'd500; car_y[1] = 10'd700;
        car_x[2] = 10'd700; car_y[2] = 10'd500;
        car_x[3] = 10'd300; car_y[3] = 10'd900;
    endtask

    function automatic logic [9:0] near(input int base);
        int v;
        v = base + int'($urandom_range(0, 80)) - 40;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return 10'(v);
    endfunction

    initial begin
        cyc = 0; hit_count = 0;
        model_reset();
        cars_far();
        #1;
        chk("rst_hit", int'(o_hit), 0);
        chk("rst_car", int'(o_hit_car), 0);
        chk("rst_ovl", int'(o_overlap), 0);
        chk("rst_inv", int'(o_invuln), 0);
        run(3);
        rst_n = 1'b1;
        gs = 2'b01;
        run(6);

        // first contact from ARMED: overlap, then pulse, then N invulnerable cycles
        car_x[1] = 10'd120; car_y[1] = 10'd100;
        hit_count = 0;
        step();
        chk("s1_ovl", int'(o_overlap), 1);
        step();
        chk("s1_hit", int'(o_hit), 1);
        chk("s1_car", int'(o_hit_car), 1);
        for (int i = 0; i < N; i++) begin
            step();
            chk("s1_inv", int'(o_invuln), 1);
        end
        step();
        chk("s1_inv_end", int'(o_invuln), 0);
        run(50 - N - 3);
        chk("sustain_one_hit", hit_count, 1);

        // drop contact for one cycle, then return: second hit
        car_x[1] = 10'd500;
        step();
        car_x[1] = 10'd120;
        hit_count = 0;
        run(6);
        chk("rehit", hit_count, 1);

        // two cars at once: single pulse naming car 2
        cars_far();
        run(N + 4);
        car_x[2] = 10'd110; car_y[2] = 10'd110;
        car_x[3] = 10'd90;  car_y[3] = 10'd90;
        hit_count = 0;
        step();
        step();
        chk("multi_hit", int'(o_hit), 1);
        chk("multi_car", int'(o_hit_car), 2);
        run(20);
        chk("multi_one_pulse", hit_count, 1);

        // edges near the right border
        cars_far();
        rac_x = 10'd1000; car_x[1] = 10'd968; car_y[1] = 10'd100;
        run(2);
        chk("edge_touch", int'(o_overlap), 0);
        rac_x = 10'd1015; car_x[1] = 10'd1000;
        step();
        chk("edge_nowrap", int'(o_overlap), 1);
        rac_x = 10'd100; rac_y = 10'd1015; car_x[1] = 10'd100; car_y[1] = 10'd1000;
        step();
        chk("edge_nowrap_y", int'(o_overlap), 1);
        rac_y = 10'd100;
        cars_far();
        run(N + 6);

        // leave running mid-invulnerability, come back clear, hit again
        car_x[1] = 10'd120; car_y[1] = 10'd100;
        run(5);
        gs = 2'b00;
        step();
        chk("gs_drop_inv", int'(o_invuln), 0);
        chk("gs_drop_car", int'(o_hit_car), 0);
        gs = 2'b01;
        cars_far();
        run(4);
        car_x[1] = 10'd120; car_y[1] = 10'd100;
        step();
        step();
        chk("gs_rearm_hit", int'(o_hit), 1);

        // short asynchronous reset pulse mid-invulnerability
        run(3);
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        model_reset();
        chk("arst_hit", int'(o_hit), 0);
        chk("arst_car", int'(o_hit_car), 0);
        chk("arst_ovl", int'(o_overlap), 0);
        chk("arst_inv", int'(o_invuln), 0);
        hit_count = 0;
        run(15);
        chk("arst_no_stray", hit_count, 0);

        // random traffic
        for (int seg = 0; seg < 150; seg++) begin
            gs = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            rac_x = 10'($urandom_range(0, 1023));
            rac_y = 10'($urandom_range(0, 1023));
            for (int c = 1; c <= 3; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    car_x[c] = near(int'(rac_x));
                    car_y[c] = near(int'(rac_y));
                end else begin
                    car_x[c] = 10'($urandom_range(0, 1023));
                    car_y[c] = 10'($urandom_range(0, 1023));
                end
            end
            run(int'($urandom_range(1, 6)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
